// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
package regfile_wr_arbiter_pkg;
  localparam int WIDTH = 16;
  localparam int DROP_W = 8;
  localparam logic [3:0] R_ZERO = 4'd0;
  localparam logic [3:0] R_ONES = 4'd15;

  // r0 and r15 are hardwired; writes to them are swallowed
  function automatic logic is_hardwired(input logic [3:0] idx);
    return (idx == R_ZERO) || (idx == R_ONES);
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshake plus register-file write port of the arbiter.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int width = WIDTH
);
  logic              freeze;
  logic              a_valid;
  logic [3:0]        a_wr;
  logic [width-1:0]  a_wd;
  logic              a_ready;
  logic              b_valid;
  logic [3:0]        b_wr;
  logic [width-1:0]  b_wd;
  logic              b_ready;
  logic              we;
  logic [3:0]        wr;
  logic [width-1:0]  wd;
  logic [15:0]       pend_mask;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output freeze, a_valid, a_wr, a_wd, b_valid, b_wr, b_wd,
    input  a_ready, b_ready, we, wr, wd, pend_mask, drop_cnt
  );

  modport slave (
    input  freeze, a_valid, a_wr, a_wd, b_valid, b_wr, b_wd,
    output a_ready, b_ready, we, wr, wd, pend_mask, drop_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer names who wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;  // 0: A wins a tie, 1: B wins a tie

  always_comb begin
    gnt = '0;
    if (en) begin
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int width = WIDTH
) (
  input logic clk,
  input logic rst_n,
  regfile_wr_arbiter_if.slave bus
);
  logic [1:0]        gnt;
  logic              acc;
  logic              hw;
  logic [3:0]        sel_wr;
  logic [width-1:0]  sel_wd;
  logic              we_q;
  logic [3:0]        wr_q;
  logic [width-1:0]  wd_q;
  logic [DROP_W-1:0] drop_q;

  // reset gates ready combinationally so nothing is accepted while held
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rst_n & ~bus.freeze),
    .req   ({bus.b_valid, bus.a_valid}),
    .gnt   (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  assign acc    = |gnt;
  assign sel_wr = gnt[1] ? bus.b_wr : bus.a_wr;
  assign sel_wd = gnt[1] ? bus.b_wd : bus.a_wd;
  assign hw     = is_hardwired(sel_wr);

  // address/data only move on a real write; dropped writes leave them alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      wr_q   <= '0;
      wd_q   <= '0;
      drop_q <= '0;
    end else begin
      we_q <= acc & ~hw;
      if (acc && !hw) begin
        wr_q <= sel_wr;
        wd_q <= sel_wd;
      end
      if (acc && hw && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.we        = we_q;
  assign bus.wr        = wr_q;
  assign bus.wd        = wd_q;
  assign bus.pend_mask = we_q ? (16'd1 << wr_q) : 16'd0;
  assign bus.drop_cnt  = drop_q;
endmodule
